// File: rtl/basic_gates_pkg.sv
// rtl/basic_gates_pkg.sv - shared widths, state encoding and golden truth table for the gates sweep checker
package basic_gates_pkg;

  localparam int NUM_GATES = 7;
  localparam int VEC_IDX_W = 2;
  localparam int ERR_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Bit order: [0]and [1]or [2]nand [3]nor [4]xor [5]xnor [6]not a
  localparam logic [NUM_GATES-1:0] GOLD_0 = 7'h6C;
  localparam logic [NUM_GATES-1:0] GOLD_1 = 7'h56;
  localparam logic [NUM_GATES-1:0] GOLD_2 = 7'h16;
  localparam logic [NUM_GATES-1:0] GOLD_3 = 7'h23;

  function automatic logic [NUM_GATES-1:0] gold_vec(input logic [VEC_IDX_W-1:0] idx);
    logic [NUM_GATES-1:0] g;
    case (idx)
      2'd0:    g = GOLD_0;
      2'd1:    g = GOLD_1;
      2'd2:    g = GOLD_2;
      default: g = GOLD_3;
    endcase
    return g;
  endfunction

  function automatic logic [ERR_W-1:0] popcount7(input logic [NUM_GATES-1:0] v);
    logic [ERR_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_GATES; i++) n = n + ERR_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/basic_gates_golden.sv
// rtl/basic_gates_golden.sv - combinational reference gates for one {a,b} vector
module basic_gates_golden
  import basic_gates_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] z
);

  assign z = {~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};

  // The gate equations and the constant table must never disagree.
  always_comb begin
    assert (z == gold_vec({a, b}));
  end

endmodule

// File: rtl/basic_gates_sweep_checker.sv
// rtl/basic_gates_sweep_checker.sv - sweeps all four {a,b} vectors and scores the gate bus against golden
module basic_gates_sweep_checker
  import basic_gates_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_GATES     = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 a,
  output logic                 b,
  input  logic [NUM_GATES-1:0] z_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [4:0]           err_count,
  output logic [6:0]           err_mask,
  output logic [1:0]           first_fail_idx,
  output logic [6:0]           first_fail_z
);

  state_t                 state, state_next;
  logic [3:0]             cnt;
  logic [VEC_IDX_W-1:0]   idx;
  logic [6:0]             expected;
  logic [6:0]             mism;

  basic_gates_golden u_golden (
    .a (a),
    .b (b),
    .z (expected)
  );

  assign mism = z_in[6:0] ^ expected;
  assign busy = (state != ST_IDLE);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_SETTLE;
      ST_SETTLE: if (cnt == 4'(SETTLE_CYCLES - 1)) state_next = ST_CHECK;
      ST_CHECK:  state_next = (idx == 2'd3) ? ST_DONE : ST_SETTLE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      idx            <= '0;
      a              <= 1'b0;
      b              <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      err_mask       <= '0;
      first_fail_idx <= '0;
      first_fail_z   <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_count      <= '0;
            err_mask       <= '0;
            first_fail_idx <= '0;
            first_fail_z   <= '0;
            pass           <= 1'b0;
            idx            <= '0;
            cnt            <= '0;
            a              <= 1'b0;
            b              <= 1'b0;
          end
        end
        ST_SETTLE: cnt <= cnt + 4'd1;
        ST_CHECK: begin
          err_count <= err_count + popcount7(mism);
          err_mask  <= err_mask | mism;
          // An empty mask means no vector has failed yet in this sweep.
          if (mism != '0 && err_mask == '0) begin
            first_fail_idx <= idx;
            first_fail_z   <= z_in[6:0];
          end
          if (idx != 2'd3) begin
            idx    <= idx + 2'd1;
            {a, b} <= idx + 2'd1;
            cnt    <= '0;
          end
        end
        ST_DONE: begin
          done <= 1'b1;
          pass <= (err_count == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_basic_gates_sweep_checker.sv
// tb/tb_basic_gates_sweep_checker.sv - randomized self-checking bench for basic_gates_sweep_checker
module tb_basic_gates_sweep_checker;

  logic       clk;
  logic       rst;
  logic       start  [2];
  logic       a_o    [2];
  logic       b_o    [2];
  logic [6:0] z      [2];
  logic       busy   [2];
  logic       done   [2];
  logic       pass   [2];
  logic [4:0] errc   [2];
  logic [6:0] emask  [2];
  logic [1:0] ffi    [2];
  logic [6:0] ffz    [2];
  logic [6:0] and_m  [2];
  logic [6:0] or_m   [2];

  int checks = 0;
  int errors = 0;
  int settle [2] = '{2, 1};

  basic_gates_sweep_checker #(.SETTLE_CYCLES(2), .NUM_GATES(7)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .a(a_o[0]), .b(b_o[0]), .z_in(z[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]), .err_mask(emask[0]),
    .first_fail_idx(ffi[0]), .first_fail_z(ffz[0])
  );

  basic_gates_sweep_checker #(.SETTLE_CYCLES(1), .NUM_GATES(7)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .a(a_o[1]), .b(b_o[1]), .z_in(z[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]), .err_mask(emask[1]),
    .first_fail_idx(ffi[1]), .first_fail_z(ffz[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] true_gates(input logic av, input logic bv);
    logic [6:0] r;
    r[0] = av & bv;
    r[1] = av | bv;
    r[2] = !(av & bv);
    r[3] = !(av | bv);
    r[4] = av ^ bv;
    r[5] = !(av ^ bv);
    r[6] = !av;
    return r;
  endfunction

  // Gates block under test, with stuck-at-0 (and_m) and stuck-at-1 (or_m) faults.
  always_comb begin
    for (int i = 0; i < 2; i++) z[i] = (true_gates(a_o[i], b_o[i]) & ~and_m[i]) | or_m[i];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [6:0] am, input logic [6:0] om, output int ec,
                       output logic [6:0] mk, output logic [1:0] fi, output logic [6:0] fz);
    ec = 0; mk = '0; fi = '0; fz = '0;
    for (int v = 0; v < 4; v++) begin
      logic [6:0] good, seen, diff;
      good = true_gates(v[1], v[0]);
      seen = (good & ~am) | om;
      diff = seen ^ good;
      if (diff != 0 && mk == 0) begin
        fi = 2'(v);
        fz = seen;
      end
      ec += $countones(diff);
      mk |= diff;
    end
  endtask

  task automatic check_reset_state(input int d, input string tag);
    check({tag, "_ab"}, {a_o[d], b_o[d]}, 0);
    check({tag, "_busy_done_pass"}, {busy[d], done[d], pass[d]}, 0);
    check({tag, "_errc"}, errc[d], 0);
    check({tag, "_emask"}, emask[d], 0);
    check({tag, "_ff"}, {ffi[d], ffz[d]}, 0);
  endtask

  task automatic run_sweep(input int d, input logic [6:0] am, input logic [6:0] om, input bit noisy);
    int cyc, s1, lat;
    bit got, ab_ok;
    int ec;
    logic [6:0] mk, fz;
    logic [1:0] fi;
    s1 = settle[d] + 1;
    lat = 4 * s1 + 1;
    and_m[d] = am;
    or_m[d]  = om;
    model(am, om, ec, mk, fi, fz);
    @(negedge clk);
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    cyc = 0; got = 0; ab_ok = 1;
    check("busy_after_start", busy[d], 1);
    while (!got && cyc < 200) begin
      if (cyc < 4 * s1 && {a_o[d], b_o[d]} != 2'(cyc / s1)) ab_ok = 0;
      start[d] = noisy && (cyc == 3 || cyc == 7 || cyc == 4 * s1);
      @(posedge clk); #1;
      cyc++;
      if (done[d]) got = 1;
    end
    start[d] = 1'b0;
    check("done_latency", cyc, lat);
    check("ab_sequence", ab_ok, 1);
    check("pass", pass[d], (ec == 0));
    check("err_count", errc[d], ec);
    check("err_mask", emask[d], mk);
    check("first_fail_idx", ffi[d], fi);
    check("first_fail_z", ffz[d], fz);
    @(posedge clk); #1;
    check("done_single_pulse", done[d], 0);
    check("idle_after_done", busy[d], 0);
    check("results_hold", {pass[d], errc[d], emask[d]}, {(ec == 0), 5'(ec), mk});
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; and_m[i] = '0; or_m[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_state(0, "rst0");
    check_reset_state(1, "rst1");
    @(negedge clk);
    rst = 1'b0;

    run_sweep(0, 7'h00, 7'h00, 0);   // clean
    run_sweep(0, 7'h10, 7'h00, 0);   // xor stuck-at-0
    run_sweep(0, 7'h7F, 7'h00, 0);   // bus stuck at 0
    run_sweep(0, 7'h00, 7'h00, 1);   // ignored starts mid-sweep and in DONE

    // Reset during the second SETTLE window.
    and_m[0] = 7'h7F; or_m[0] = '0;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state(0, "midrst");
    saw_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done[0]) saw_done = 1;
    end
    check("midrst_no_done", saw_done, 0);
    run_sweep(0, 7'h00, 7'h00, 0);

    // Short settle: fault then clean, second fully replaces first.
    run_sweep(1, 7'h21, 7'h02, 0);
    run_sweep(1, 7'h00, 7'h00, 0);

    for (int r = 0; r < 8; r++) begin
      logic [6:0] am, om;
      am = 7'($urandom);
      om = 7'($urandom) & ~am;
      if ($urandom_range(0, 2) == 0) begin am = '0; om = '0; end
      run_sweep(int'($urandom_range(0, 1)), am, om, bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
